// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and small helpers for the HD44780 refresh sequencer.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_ROW0     = 8'h80;
    localparam logic [7:0] LCD_ROW1     = 8'hC0;

    // Wide enough for the 20 ms power-on wait at 50 MHz.
    localparam int CNT_W = 20;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        ADDR1,
        ROW1,
        ADDR2,
        ROW2
    } lcd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_WAIT
    } wr_phase_t;

    function automatic logic [7:0] init_byte(input logic [1:0] step);
        logic [7:0] b;
        case (step)
            2'd0:    b = LCD_FUNC_SET;
            2'd1:    b = LCD_DISP_ON;
            2'd2:    b = LCD_CLEAR;
            default: b = LCD_ENTRY;
        endcase
        return b;
    endfunction

    // Character 0 lives in the top byte of the packed line.
    function automatic logic [7:0] char_at(input logic [127:0] line, input logic [3:0] idx);
        logic [127:0] sh;
        sh = line << {idx, 3'b000};
        return sh[127:120];
    endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Drives one byte onto the panel: one setup cycle, an E pulse, then the post-byte wait.
// done is high when a new start can be accepted, including the last wait cycle.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int E_PULSE_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       is_cmd,
    input  logic [7:0] data,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data
);

    wr_phase_t        phase;
    logic [CNT_W-1:0] cnt;
    logic             is_clear;

    assign done = (phase == WR_IDLE) || ((phase == WR_WAIT) && (cnt == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase    <= WR_IDLE;
            cnt      <= '0;
            is_clear <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else if (start && done) begin
            lcd_data <= data;
            lcd_rs   <= ~is_cmd;
            is_clear <= is_cmd && (data == LCD_CLEAR);
            phase    <= WR_SETUP;
        end else begin
            case (phase)
                WR_SETUP: begin
                    lcd_e <= 1'b1;
                    cnt   <= CNT_W'(E_PULSE_CYC - 1);
                    phase <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b0;
                        cnt   <= is_clear ? CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
                        phase <= WR_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (cnt == '0) phase <= WR_IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: phase <= WR_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// 2x16 HD44780 sequencer: power-on init, then snapshots both rows and streams them on request.
//   state    | meaning
//   PWR_WAIT | counting down the power-on delay
//   INIT     | init command idx in flight
//   IDLE     | panel up to date, waiting for refresh
//   ADDR1    | row 0 address command in flight
//   ROW1     | row 0 char idx in flight
//   ADDR2    | row 1 address command in flight
//   ROW2     | row 1 char idx in flight
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int E_PULSE_CYC      = 12,
    parameter int CMD_WAIT_CYC     = 2500,
    parameter int CLEAR_WAIT_CYC   = 100000,
    parameter int POWERON_WAIT_CYC = 1000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] line1_chars,
    input  logic [127:0] line2_chars,
    input  logic         refresh,
    output logic         ready,
    output logic         busy,
    output logic         lcd_e,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_data
);

    lcd_state_t       state, next_state;
    logic [3:0]       idx;
    logic [CNT_W-1:0] pwr_cnt;
    logic [127:0]     snap1, snap2;
    logic             pending;
    logic             wr_done;
    logic             issue, issue_cmd, frame_start;
    logic [7:0]       issue_byte;

    assign lcd_rw = 1'b0;

    // Each transition issues the next byte in the same edge, so bytes are back to back.
    always_comb begin
        issue       = 1'b0;
        issue_cmd   = 1'b1;
        issue_byte  = 8'h00;
        frame_start = 1'b0;
        next_state  = state;
        case (state)
            PWR_WAIT: if (pwr_cnt == '0) begin
                issue      = 1'b1;
                issue_byte = init_byte(2'd0);
                next_state = INIT;
            end
            INIT: if (wr_done) begin
                issue = 1'b1;
                if (idx == 4'd3) begin
                    frame_start = 1'b1;
                    issue_byte  = LCD_ROW0;
                    next_state  = ADDR1;
                end else begin
                    issue_byte = init_byte(idx[1:0] + 2'd1);
                end
            end
            IDLE: if (refresh) begin
                issue       = 1'b1;
                frame_start = 1'b1;
                issue_byte  = LCD_ROW0;
                next_state  = ADDR1;
            end
            ADDR1: if (wr_done) begin
                issue      = 1'b1;
                issue_cmd  = 1'b0;
                issue_byte = char_at(snap1, 4'd0);
                next_state = ROW1;
            end
            ROW1: if (wr_done) begin
                issue = 1'b1;
                if (idx == 4'd15) begin
                    issue_byte = LCD_ROW1;
                    next_state = ADDR2;
                end else begin
                    issue_cmd  = 1'b0;
                    issue_byte = char_at(snap1, idx + 4'd1);
                end
            end
            ADDR2: if (wr_done) begin
                issue      = 1'b1;
                issue_cmd  = 1'b0;
                issue_byte = char_at(snap2, 4'd0);
                next_state = ROW2;
            end
            ROW2: if (wr_done) begin
                if (idx != 4'd15) begin
                    issue      = 1'b1;
                    issue_cmd  = 1'b0;
                    issue_byte = char_at(snap2, idx + 4'd1);
                end else if (pending || refresh) begin
                    issue       = 1'b1;
                    frame_start = 1'b1;
                    issue_byte  = LCD_ROW0;
                    next_state  = ADDR1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= PWR_WAIT;
            idx     <= 4'd0;
            pwr_cnt <= CNT_W'(POWERON_WAIT_CYC - 1);
            snap1   <= '0;
            snap2   <= '0;
            pending <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            if (state == PWR_WAIT && pwr_cnt != '0)
                pwr_cnt <= pwr_cnt - 1'b1;
            if (issue)
                idx <= (next_state == state) ? idx + 4'd1 : 4'd0;
            if (frame_start) begin
                snap1 <= line1_chars;
                snap2 <= line2_chars;
            end
            if (state == INIT && frame_start)
                ready <= 1'b1;
            // The automatic first frame does not consume a request made during init.
            if (frame_start && state != INIT)
                pending <= 1'b0;
            else if (refresh)
                pending <= 1'b1;
        end
    end

    lcd_byte_writer #(
        .E_PULSE_CYC    (E_PULSE_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
    ) u_writer (
        .clk      (clk),
        .reset    (reset),
        .start    (issue),
        .is_cmd   (issue_cmd),
        .data     (issue_byte),
        .done     (wr_done),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_data (lcd_data)
    );

endmodule
